dff_en: RTL and testbench
=========================

# dff_en

Enabled D flip-flop register with asynchronous active-low reset. It captures `data` into `q` on a rising clock edge when `en` is high and holds `q` otherwise. It is the basic storage element for control and status bits throughout the design. Width and reset value are parameters, so one block covers single-bit flags and multi-bit registers.

## Interface

Parameters:
- `WIDTH`, default 1: bit width of `data` and `q`; legal range ≥ 1.
- `RESET_VALUE`, default all-zeros (`{WIDTH{1'b0}}`): value loaded into `q` while reset is asserted.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  reset, asynchronous, active-low; `reset = 0` forces `q` to `RESET_VALUE`.
- `en`  input  1  load enable, active-high, sampled on the rising edge of `clk`.
- `data`  input  `WIDTH`  next-state value, sampled on the rising edge of `clk` when `en = 1`.
- `q`  output  `WIDTH`  registered output, driven directly from the storage flops with no combinational logic.

## Operation

- Reset asserted (`reset = 0`): `q` = `RESET_VALUE` immediately, regardless of `clk`, `en` and `data`. `q` stays there for as long as reset is held low.
- Reset deasserted (`reset = 1`), rising `clk` edge with `en = 1`: `q` <= `data`.
- Reset deasserted, rising `clk` edge with `en = 0`: `q` holds its previous value.
- Between rising edges: `q` is stable, and changes on `data` or `en` have no effect.
- No other state exists. The block has no handshake and no backpressure.
- X/Z on `en` or `data`: behaviour is undefined. Verification must not drive X on these inputs after reset is released.

## Timing

- Load latency is 1 cycle: `data` presented before a rising edge with `en = 1` appears on `q` just after that edge.
- Reset assertion is asynchronous. `q` reaches `RESET_VALUE` within the flop clock-to-q/reset-to-q delay, with no clock edge needed.
- Reset deassertion:
  - The first possible load is the first rising edge at which `reset = 1` is already stable.
  - Reset release must meet recovery/removal timing against `clk`. Synchronising the release is the responsibility of the upstream reset generator.
- Reset asserted mid-operation: the reset wins immediately and any load in progress is discarded.
- Simultaneous events:
  - Reset low coincident with a rising edge and `en = 1`: `q` = `RESET_VALUE`.
  - `en` and `data` changing in the same cycle: both are sampled together at the next rising edge.
- Output `q` is glitch-free and a pure flop output, so it is safe to use as a clock-domain source.
- Bench clock: 10 ns period, rising edges at 5, 15, 25, … ns. The bench changes stimulus away from rising edges.

## Test plan

All scenarios use `WIDTH = 1`, `RESET_VALUE = 0` unless stated otherwise.

1. Hold `reset = 0`, `en = 0`, `data = 0` for 10 ns -> `q = 0`.
2. Release reset, then set `en = 0`, `data = 1` for one cycle -> `q` stays 0 (no load while disabled).
3. Set `en = 1`, `data = 0` for one cycle -> `q = 0`. Then set `data = 1` for one cycle -> `q = 1` after the next rising edge.
4. With `q = 1`, set `en = 0`, `data = 0` for one cycle -> `q` holds 1.
5. With `q = 1`, drive `reset = 0` mid-cycle (between edges) -> `q = 0` immediately, before any clock edge, and it remains 0 while reset is low, even with `en = 1`, `data = 1`.
6. With `WIDTH = 8`, `RESET_VALUE = 8'hA5`:
   - During reset -> `q = 8'hA5`.
   - After release, `en = 1`, `data = 8'h3C` -> `q = 8'h3C` after one edge.
   - Then `en = 0`, `data = 8'hFF` -> `q` stays `8'h3C`.

Source files
------------

// File: rtl/dff_en.sv
// dff_en: enabled D flip-flop register with asynchronous active-low reset.
// The WIDTH and RESET_VALUE parameters let one block serve as a
// single-bit flag or as a multi-bit control/status register.
module dff_en #(
  parameter int unsigned WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q
);

  // Storage: reset forces RESET_VALUE at once; otherwise load data when enabled, else hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= data;
    end
  end

endmodule

// File: tb/tb_dff_en.sv
// tb_dff_en: directed self-checking bench for dff_en. It uses a 1-bit
// instance with a zero reset value and an 8-bit instance that resets to 8'hA5.
`timescale 1ns/1ps
module tb_dff_en;

  logic       clk;
  logic       reset1, en1, data1;
  logic       q1;
  logic       reset8, en8;
  logic [7:0] data8;
  logic [7:0] q8;

  int unsigned n_checks;
  int unsigned n_fail;

  dff_en u_bit (
    .clk   (clk),
    .reset (reset1),
    .en    (en1),
    .data  (data1),
    .q     (q1)
  );

  dff_en #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) u_byte (
    .clk   (clk),
    .reset (reset8),
    .en    (en8),
    .data  (data8),
    .q     (q8)
  );

  // Rising edges at 5, 15, 25, ... ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // t=0: both instances in reset; the byte instance sees en=1 across the edge at 5.
    reset1 = 1'b0; en1 = 1'b0; data1 = 1'b0;
    reset8 = 1'b0; en8 = 1'b1; data8 = 8'hFF;
    #10; // t=10
    check("bit_reset_q0", {7'b0, q1}, 8'h00);
    check("byte_reset_a5", q8, 8'hA5);

    // t=10: release both resets; bit instance disabled with data=1.
    reset1 = 1'b1; en1 = 1'b0; data1 = 1'b1;
    reset8 = 1'b1; en8 = 1'b1; data8 = 8'h3C;
    #10; // t=20, after edge 15
    check("bit_no_load_disabled", {7'b0, q1}, 8'h00);
    check("byte_load_3c", q8, 8'h3C);

    // t=20
    en1 = 1'b1; data1 = 1'b0;
    en8 = 1'b0; data8 = 8'hFF;
    #10; // t=30
    check("bit_load_0", {7'b0, q1}, 8'h00);
    check("byte_hold_3c", q8, 8'h3C);

    // t=30
    data1 = 1'b1;
    en8 = 1'b1; data8 = 8'h5A;
    #10; // t=40
    check("bit_load_1", {7'b0, q1}, 8'h01);
    check("byte_load_5a", q8, 8'h5A);

    // t=40: hold test
    en1 = 1'b0; data1 = 1'b0;
    #2; // t=42: asynchronous reset of the byte instance mid-cycle, with en=1
    reset8 = 1'b0; en8 = 1'b1; data8 = 8'h77;
    #1; // t=43
    check("byte_async_reset", q8, 8'hA5);
    #7; // t=50, after edge 45
    check("bit_hold_1", {7'b0, q1}, 8'h01);
    check("byte_reset_held", q8, 8'hA5);

    // t=52: asynchronous reset of the bit instance mid-cycle
    #2;
    reset1 = 1'b0; en1 = 1'b1; data1 = 1'b1;
    #1; // t=53, before edge 55
    check("bit_async_reset", {7'b0, q1}, 8'h00);
    #7; // t=60
    check("bit_reset_held_a", {7'b0, q1}, 8'h00);
    #10; // t=70
    check("bit_reset_held_b", {7'b0, q1}, 8'h00);

    // t=70: release; first edge at 75 loads
    reset1 = 1'b1; en1 = 1'b1; data1 = 1'b1;
    reset8 = 1'b1; en8 = 1'b1; data8 = 8'hC3;
    #10; // t=80
    check("bit_first_load_after_release", {7'b0, q1}, 8'h01);
    check("byte_first_load_after_release", q8, 8'hC3);

    // t=82: change inputs between edges; q must not move until edge 85
    #2;
    data1 = 1'b0;
    data8 = 8'h81;
    #2; // t=84
    check("bit_stable_between_edges", {7'b0, q1}, 8'h01);
    check("byte_stable_between_edges", q8, 8'hC3);
    #6; // t=90
    check("bit_load_after_change", {7'b0, q1}, 8'h00);
    check("byte_load_after_change", q8, 8'h81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
